// File: rtl/mux_scan_ctrl.sv
// Holds one 16-bit word on the inputs of an external 16:1 mux and walks the
// (bit-reversed) select through all 16 lanes under valid/ready handshaking.
module mux_scan_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] mux_data,
  output logic [3:0]  mux_sel,
  output logic        bit_valid,
  output logic        bit_last,
  input  logic        bit_ready,
  output logic [15:0] word_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [3:0] FIRST_IDX = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] LAST_IDX  = MSB_FIRST ? 4'd0  : 4'd15;

  logic [0:0]  state_r;
  logic [3:0]  idx_r;
  logic [15:0] data_r;
  logic [15:0] cnt_r;

  logic        beat_s;
  logic        last_beat_s;
  logic        in_ready_s;
  logic        accept_s;
  logic [3:0]  idx_step_s;

  assign bit_valid = (state_r == SCAN);
  assign bit_last  = bit_valid && (idx_r == LAST_IDX);
  assign mux_data  = data_r;
  assign mux_sel   = {idx_r[0], idx_r[1], idx_r[2], idx_r[3]};
  assign word_cnt  = cnt_r;
  assign in_ready  = in_ready_s;

  // Handshake decode; flush blocks both bit consumption and word acceptance.
  always_comb begin
    beat_s      = bit_valid & bit_ready & ~flush;
    last_beat_s = beat_s & bit_last;
    if (flush) begin
      in_ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = last_beat_s;
    end
    accept_s = in_valid & in_ready_s;
    if (MSB_FIRST) begin
      idx_step_s = idx_r - 4'd1;
    end else begin
      idx_step_s = idx_r + 4'd1;
    end
  end

  // Scan state, lane index, held word and completed-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      data_r  <= 16'h0000;
      cnt_r   <= 16'h0000;
    end else if (flush) begin
      state_r <= IDLE;
    end else begin
      // In SCAN a word is only accepted on the last beat, giving zero-bubble reload.
      if (accept_s) begin
        data_r  <= in_data;
        idx_r   <= FIRST_IDX;
        state_r <= SCAN;
      end else if (last_beat_s) begin
        state_r <= IDLE;
      end else if (beat_s) begin
        idx_r <= idx_step_s;
      end else begin
        state_r <= state_r;
      end
      if (last_beat_s) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule
